// File: rtl/analog_scan_sequencer_if.sv
// analog_scan_sequencer_if: Wishbone classic slave bus bundle for the scan sequencer
interface analog_scan_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/analog_scan_sequencer.sv
// analog_scan_sequencer: Wishbone-controlled settle/convert/capture scan over NCH analog channels
module analog_scan_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int NCH = 4,
  parameter int DW = 12,
  parameter int TMO = 1023,
  localparam int SELW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  analog_scan_sequencer_if.slave wb,
  output logic [SELW-1:0]        sel_o,
  output logic                   sel_oeb,
  output logic                   conv_o,
  input  logic                   done_i,
  input  logic [DW-1:0]          data_i,
  output logic                   irq_o
);
  typedef enum logic [2:0] {IDLE, SELECT, CONVERT, WAIT, CAPTURE, END} state_t;
  state_t          state_q;
  logic            ack_q, cont_q, irq_en_q, done_q, tmoerr_q, to_q;
  logic            done_s1_q, done_s2_q, sel_oeb_q, conv_q;
  logic [31:0]     dat_q, rd;
  logic [NCH-1:0]  chmask_q, scan_q;
  logic [15:0]     settle_q, cnt_q, settle_m1;
  logic [SELW-1:0] ch_q, low_ch, nxt_ch;
  logic            nxt_ok, hit, wr, start, abort, tmo_hit, done_set, tmo_set, unused;
  logic [5:0]      off, ridx;
  logic [DW-1:0]   result_q [NCH];
  assign off       = wb.wbs_adr_i[7:2];
  assign ridx      = off - 6'd4;
  assign hit       = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr        = hit & wb.wbs_we_i;
  assign start     = wr & (off == 6'd0) & wb.wbs_dat_i[0];
  assign abort     = wr & (off == 6'd0) & wb.wbs_dat_i[3];
  assign tmo_hit   = (state_q == WAIT) & ~done_s2_q & (cnt_q == 16'(TMO - 1));
  assign done_set  = ~abort & ((state_q == END) | ((state_q == IDLE) & start & ~|chmask_q));
  assign tmo_set   = ~abort & tmo_hit;
  assign settle_m1 = (settle_q == 16'd0) ? 16'd0 : settle_q - 16'd1;
  assign unused    = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], wb.wbs_dat_i, ridx};
  assign rd = (off == 6'd0) ? {29'd0, irq_en_q, cont_q, 1'b0}
            : (off == 6'd1) ? 32'(chmask_q)
            : (off == 6'd2) ? {16'd0, settle_q}
            : (off == 6'd3) ? {21'd0, 3'(ch_q), 5'd0, tmoerr_q, done_q, state_q != IDLE}
            : (off >= 6'd4 && off < 6'(4 + NCH)) ? 32'(result_q[ridx[SELW-1:0]]) : 32'd0;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign sel_o        = ch_q;
  assign sel_oeb      = sel_oeb_q;
  assign conv_o       = conv_q;
  assign irq_o        = irq_en_q & done_q;
  // descending walk leaves the lowest matching index in each result
  always_comb begin
    low_ch = '0;
    nxt_ch = '0;
    nxt_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chmask_q[i]) low_ch = SELW'(i);
      if (scan_q[i] && i > int'(ch_q)) begin
        nxt_ch = SELW'(i);
        nxt_ok = 1'b1;
      end
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      cont_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      tmoerr_q  <= 1'b0;
      to_q      <= 1'b0;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      sel_oeb_q <= 1'b1;
      conv_q    <= 1'b0;
      chmask_q  <= '0;
      scan_q    <= '0;
      settle_q  <= 16'd16;
      cnt_q     <= 16'd0;
      ch_q      <= '0;
      for (int i = 0; i < NCH; i++) result_q[i] <= '0;
    end else begin
      ack_q     <= hit;
      dat_q     <= (hit & ~wb.wbs_we_i) ? rd : 32'd0;
      done_s1_q <= done_i;
      done_s2_q <= done_s1_q;
      if (wr && off == 6'd0) {irq_en_q, cont_q} <= wb.wbs_dat_i[2:1];
      if (wr && off == 6'd1) chmask_q <= wb.wbs_dat_i[NCH-1:0];
      if (wr && off == 6'd2) settle_q <= wb.wbs_dat_i[15:0];
      done_q   <= done_set | (done_q & ~(wr && off == 6'd3 && wb.wbs_dat_i[1]));
      tmoerr_q <= tmo_set | (tmoerr_q & ~(wr && off == 6'd3 && wb.wbs_dat_i[2]));
      conv_q   <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        sel_oeb_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start && |chmask_q) begin
            state_q   <= SELECT;
            ch_q      <= low_ch;
            scan_q    <= chmask_q;
            cnt_q     <= 16'd0;
            sel_oeb_q <= 1'b0;
          end
          SELECT: if (cnt_q >= settle_m1) begin
            state_q <= CONVERT;
            conv_q  <= 1'b1;
          end else cnt_q <= cnt_q + 16'd1;
          CONVERT: begin
            state_q <= WAIT;
            cnt_q   <= 16'd0;
          end
          WAIT: if (done_s2_q || tmo_hit) begin
            state_q <= CAPTURE;
            to_q    <= tmo_hit;
          end else cnt_q <= cnt_q + 16'd1;
          CAPTURE: begin
            result_q[ch_q] <= to_q ? '1 : data_i;
            cnt_q          <= 16'd0;
            state_q        <= nxt_ok ? SELECT : END;
            if (nxt_ok) ch_q <= nxt_ch;
          end
          END: if (cont_q && |chmask_q) begin
            state_q <= SELECT;
            ch_q    <= low_ch;
            scan_q  <= chmask_q;
            cnt_q   <= 16'd0;
          end else begin
            state_q   <= IDLE;
            sel_oeb_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_analog_scan_sequencer.sv
// tb_analog_scan_sequencer: register vectors, directed scan corners and random scans vs a channel-list model
module tb_analog_scan_sequencer;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam int TMO = 1023;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done_i = 1'b0;
  logic [11:0] data_i = 12'd0;
  logic [1:0]  sel_o;
  logic        sel_oeb, conv_o, irq_o;
  int          checks = 0, errors = 0;
  int          convs = 0, since = 0, dwait = 0, dhold = 0;
  int          dly = 5;
  bit          no_done = 1'b0;
  logic [11:0] chdata [4];
  logic [1:0]  chq [$];
  int          holdq [$];
  time         last_conv_t = 0;
  logic        prev_oeb = 1'b1;
  logic [1:0]  prev_sel = 2'd0;
  analog_scan_sequencer_if wif ();
  analog_scan_sequencer dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wb(wif), .sel_o(sel_o), .sel_oeb(sel_oeb),
    .conv_o(conv_o), .done_i(done_i), .data_i(data_i), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  // converter model: done_i rises dly cycles after each convert pulse, held 4 cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      since = 0;
      dwait = 0;
      dhold = 0;
      done_i = 1'b0;
    end else begin
      if (dwait > 0) begin
        dwait--;
        if (dwait == 0) begin
          done_i = 1'b1;
          data_i = chdata[sel_o];
          dhold = 4;
        end
      end else if (dhold > 0) begin
        dhold--;
        if (dhold == 0) done_i = 1'b0;
      end
      if (conv_o) begin
        convs++;
        chq.push_back(sel_o);
        holdq.push_back(since);
        last_conv_t = $time;
        if (!no_done) dwait = dly;
      end
      since = (!sel_oeb && (prev_oeb || sel_o != prev_sel)) ? 1 : since + 1;
    end
    prev_oeb = sel_oeb;
    prev_sel = sel_o;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d,
                    output logic ack, output logic [31:0] q);
    @(negedge clk);
    wif.wbs_stb_i = 1'b1;
    wif.wbs_cyc_i = 1'b1;
    wif.wbs_we_i  = we;
    wif.wbs_adr_i = a;
    wif.wbs_dat_i = d;
    ack = 1'b0;
    q = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wif.wbs_ack_o) begin
        ack = 1'b1;
        q = wif.wbs_dat_o;
        break;
      end
    end
    wif.wbs_stb_i = 1'b0;
    wif.wbs_cyc_i = 1'b0;
    wif.wbs_we_i  = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic ack;
    logic [31:0] q;
    wb(1'b1, a, d, ack, q);
    chk($sformatf("wr_ack_%0h", a), ack, 1'b1);
  endtask
  task automatic rdchk(input string n, input logic [31:0] a, input logic [31:0] e);
    logic ack;
    logic [31:0] q;
    wb(1'b0, a, 32'd0, ack, q);
    chk(n, q, e);
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (!sel_oeb && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", n < lim, 1'b1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    vec_t        vt [18];
    logic        ack;
    logic [31:0] q;
    logic [3:0]  m;
    int          base, hb, eff, hi, el, n;
    logic [11:0] exp_res [4];
    logic [1:0]  expq [$];
    vt[0]  = '{1'b0, B + 32'h08, 32'h0, 1'b1, 32'h10};
    vt[1]  = '{1'b0, B + 32'h0C, 32'h0, 1'b1, 32'h0};
    vt[2]  = '{1'b0, B + 32'h00, 32'h0, 1'b1, 32'h0};
    vt[3]  = '{1'b0, B + 32'h04, 32'h0, 1'b1, 32'h0};
    vt[4]  = '{1'b0, B + 32'h10, 32'h0, 1'b1, 32'h0};
    vt[5]  = '{1'b1, B + 32'h04, 32'hFFFF_FFF5, 1'b1, 32'h0};
    vt[6]  = '{1'b0, B + 32'h04, 32'h0, 1'b1, 32'h5};
    vt[7]  = '{1'b1, B + 32'h08, 32'hABCD_1234, 1'b1, 32'h0};
    vt[8]  = '{1'b0, B + 32'h08, 32'h0, 1'b1, 32'h1234};
    vt[9]  = '{1'b1, B + 32'h00, 32'h6, 1'b1, 32'h0};
    vt[10] = '{1'b0, B + 32'h00, 32'h0, 1'b1, 32'h6};
    vt[11] = '{1'b1, B + 32'h00, 32'h0, 1'b1, 32'h0};
    vt[12] = '{1'b0, B + 32'h00, 32'h0, 1'b1, 32'h0};
    vt[13] = '{1'b0, B + 32'h40, 32'h0, 1'b1, 32'h0};
    vt[14] = '{1'b0, B + 32'h100, 32'h0, 1'b0, 32'h0};
    vt[15] = '{1'b1, B + 32'h100, 32'h7, 1'b0, 32'h0};
    vt[16] = '{1'b1, B + 32'h10, 32'hFFF, 1'b1, 32'h0};
    vt[17] = '{1'b0, B + 32'h24, 32'h0, 1'b1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      chdata[i] = 12'd0;
      exp_res[i] = 12'd0;
    end
    wif.wbs_stb_i = 1'b0;
    wif.wbs_cyc_i = 1'b0;
    wif.wbs_we_i  = 1'b0;
    wif.wbs_sel_i = 4'hF;
    wif.wbs_adr_i = 32'd0;
    wif.wbs_dat_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_sel_oeb", sel_oeb, 1'b1);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_conv", conv_o, 1'b0);
    chk("rst_sel", sel_o, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wb(vt[i].we, vt[i].adr, vt[i].dat, ack, q);
      chk($sformatf("vec%0d_ack", i), ack, vt[i].ack);
      if (!vt[i].we) chk($sformatf("vec%0d_dat", i), q, vt[i].exp);
    end
    // stb held across two transfers: ack must drop for a cycle between them
    @(negedge clk);
    wif.wbs_stb_i = 1'b1;
    wif.wbs_cyc_i = 1'b1;
    wif.wbs_we_i  = 1'b1;
    wif.wbs_adr_i = B + 32'h04;
    wif.wbs_dat_i = 32'hA;
    @(negedge clk);
    chk("b2b_ack1", wif.wbs_ack_o, 1'b1);
    wif.wbs_we_i = 1'b0;
    @(negedge clk);
    chk("b2b_gap1", wif.wbs_ack_o, 1'b0);
    @(negedge clk);
    chk("b2b_ack2", wif.wbs_ack_o, 1'b1);
    chk("b2b_rdat", wif.wbs_dat_o, 32'hA);
    wif.wbs_we_i = 1'b1;
    wif.wbs_dat_i = 32'h3;
    @(negedge clk);
    chk("b2b_gap2", wif.wbs_ack_o, 1'b0);
    @(negedge clk);
    chk("b2b_ack3", wif.wbs_ack_o, 1'b1);
    wif.wbs_stb_i = 1'b0;
    wif.wbs_cyc_i = 1'b0;
    wif.wbs_we_i  = 1'b0;
    @(negedge clk);
    chk("b2b_ack_low", wif.wbs_ack_o, 1'b0);
    chk("b2b_dat_idle", wif.wbs_dat_o, 32'h0);
    rdchk("b2b_final", B + 32'h04, 32'h3);
    // two-channel scan with irq
    wr(B + 32'h04, 32'h5);
    wr(B + 32'h08, 32'h3);
    chdata[0] = 12'h123;
    chdata[2] = 12'h456;
    dly = 5;
    base = convs;
    hb = chq.size();
    wr(B, 32'h5);
    wr(B, 32'h5);
    wait_idle(500);
    chk("t2_convs", convs - base, 2);
    chk("t2_first_ch", chq[hb], 2'd0);
    chk("t2_second_ch", chq[hb+1], 2'd2);
    chk("t2_hold0", holdq[hb], 3);
    chk("t2_hold1", holdq[hb+1], 3);
    rdchk("t2_result0", B + 32'h10, 32'h123);
    rdchk("t2_result2", B + 32'h18, 32'h456);
    rdchk("t2_status", B + 32'h0C, 32'h202);
    chk("t2_irq", irq_o, 1'b1);
    wr(B + 32'h0C, 32'h2);
    chk("t2_irq_clr", irq_o, 1'b0);
    exp_res[0] = 12'h123;
    exp_res[2] = 12'h456;
    // converter never answers
    no_done = 1'b1;
    wr(B + 32'h04, 32'h1);
    base = convs;
    hb = chq.size();
    wr(B, 32'h1);
    wait_idle(TMO + 200);
    el = int'(($time - last_conv_t) / 10);
    chk("t3_convs", convs - base, 1);
    chk("t3_hold", holdq[hb], 3);
    chk("t3_tmo_window", (el >= TMO + 1) && (el <= TMO + 5), 1'b1);
    rdchk("t3_result0", B + 32'h10, 32'hFFF);
    rdchk("t3_status", B + 32'h0C, 32'h006);
    chk("t3_irq_off", irq_o, 1'b0);
    wr(B + 32'h0C, 32'h6);
    rdchk("t3_status_clr", B + 32'h0C, 32'h0);
    no_done = 1'b0;
    exp_res[0] = 12'hFFF;
    // empty mask
    wr(B + 32'h04, 32'h0);
    base = convs;
    wr(B, 32'h1);
    chk("t4_oeb", sel_oeb, 1'b1);
    rdchk("t4_status", B + 32'h0C, 32'h002);
    chk("t4_oeb_after", sel_oeb, 1'b1);
    chk("t4_no_conv", convs - base, 0);
    wr(B + 32'h0C, 32'h2);
    // continuous on ch3, then abort in WAIT
    wr(B + 32'h04, 32'h8);
    dly = 20;
    base = convs;
    hb = chq.size();
    wr(B, 32'h3);
    n = 0;
    while (convs - base < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cont_passes", convs - base >= 3, 1'b1);
    for (int k = 0; k < 3; k++) chk($sformatf("t5_ch_%0d", k), chq[hb+k], 2'd3);
    wr(B + 32'h0C, 32'h2);
    wr(B, 32'h8);
    chk("t5_abort_oeb", sel_oeb, 1'b1);
    chk("t5_abort_conv", conv_o, 1'b0);
    base = convs;
    repeat (60) @(negedge clk);
    chk("t5_no_conv", convs - base, 0);
    rdchk("t5_status", B + 32'h0C, 32'h300);
    wr(B + 32'h04, 32'h1);
    base = convs;
    wr(B, 32'h9);
    chk("t5_abstart_oeb", sel_oeb, 1'b1);
    repeat (20) @(negedge clk);
    chk("t5_abstart_conv", convs - base, 0);
    rdchk("t5_abstart_status", B + 32'h0C, 32'h300);
    // random scans checked against the enabled-channel list
    for (int r = 0; r < 12; r++) begin
      m = 4'($urandom_range(1, 15));
      n = $urandom_range(0, 6);
      eff = (n == 0) ? 1 : n;
      dly = $urandom_range(1, 10);
      for (int i = 0; i < 4; i++) chdata[i] = 12'($urandom_range(0, 12'hFFE));
      expq.delete();
      hi = 0;
      for (int i = 0; i < 4; i++) if (m[i]) begin
        expq.push_back(2'(i));
        exp_res[i] = chdata[i];
        hi = i;
      end
      wr(B + 32'h04, 32'(m));
      wr(B + 32'h08, 32'(n));
      base = convs;
      hb = chq.size();
      wr(B, 32'h1);
      wait_idle(1000);
      chk($sformatf("r%0d_convs", r), convs - base, $countones(m));
      for (int k = 0; k < expq.size(); k++) begin
        chk($sformatf("r%0d_ch%0d", r, k), chq[hb+k], expq[k]);
        chk($sformatf("r%0d_hold%0d", r, k), holdq[hb+k], eff);
      end
      for (int i = 0; i < 4; i++)
        rdchk($sformatf("r%0d_result%0d", r, i), B + 32'h10 + 32'(4 * i), 32'(exp_res[i]));
      rdchk($sformatf("r%0d_status", r), B + 32'h0C, 32'h002 | 32'(hi << 8));
      wr(B + 32'h0C, 32'h2);
    end
    // reset mid-scan
    wr(B + 32'h04, 32'hF);
    wr(B + 32'h08, 32'h8);
    base = convs;
    wr(B, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_oeb", sel_oeb, 1'b1);
    chk("rst_mid_conv", conv_o, 1'b0);
    chk("rst_mid_sel", sel_o, 2'd0);
    repeat (10) @(negedge clk);
    chk("rst_mid_no_conv", convs - base, 0);
    rst_n = 1'b1;
    rdchk("rst_mid_settle", B + 32'h08, 32'h10);
    rdchk("rst_mid_mask", B + 32'h04, 32'h0);
    rdchk("rst_mid_result0", B + 32'h10, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
